// File: rtl/calc_sequencer.sv
// calc_sequencer: collects two operands and an op code from switches, one per
// load-button press, presents them to a combinational calculator, and latches
// the returned result for the display.
module calc_sequencer #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   data_in,
  input  logic [3:0]     op_in,
  input  logic           load,
  input  logic           clear,
  output logic [N-1:0]   operand1,
  output logic [N-1:0]   operand2,
  output logic [3:0]     op_select,
  input  logic [2*N-1:0] resultado,
  output logic [2*N-1:0] result,
  output logic           result_valid,
  output logic           div_zero,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;

  state_t state_q;
  logic   load_q;
  logic   load_evt;

  // A held button is a single press: only the low-to-high transition counts.
  assign load_evt = load & ~load_q;
  assign state    = state_q;

  // Sequencer FSM; operands only move in the capture states so the calculator
  // sees stable inputs through EXEC and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= GET_A;
      load_q       <= 1'b0;
      operand1     <= '0;
      operand2     <= '0;
      op_select    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      load_q <= load;
      if (clear) begin
        // Abort wins over any coincident press.
        state_q      <= GET_A;
        operand1     <= '0;
        operand2     <= '0;
        op_select    <= '0;
        result       <= '0;
        result_valid <= 1'b0;
        div_zero     <= 1'b0;
      end else begin
        case (state_q)
          GET_A: if (load_evt) begin
            operand1 <= data_in;
            state_q  <= GET_B;
          end
          GET_B: if (load_evt) begin
            operand2 <= data_in;
            state_q  <= GET_OP;
          end
          GET_OP: if (load_evt) begin
            op_select <= op_in;
            state_q   <= EXEC;
          end
          // Single settle cycle for the calculator; presses here are dropped.
          EXEC: begin
            result       <= resultado;
            result_valid <= 1'b1;
            div_zero     <= ((op_select == OP_DIV) || (op_select == OP_MOD)) &&
                            (operand2 == '0);
            state_q      <= DONE;
          end
          // Next press starts a new calculation with this value as operand1;
          // the old result stays on the display until replaced.
          DONE: if (load_evt) begin
            operand1     <= data_in;
            result_valid <= 1'b0;
            div_zero     <= 1'b0;
            state_q      <= GET_B;
          end
          default: state_q <= GET_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (N=4) with a small calculator model on
// the operand/op outputs.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_in = '0;
  logic [3:0] op_in = '0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] operand1, operand2, op_select;
  logic [7:0] resultado, result;
  logic       result_valid, div_zero;
  logic [2:0] state;

  int compared = 0;
  int mismatched = 0;

  calc_sequencer #(.N(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op_in(op_in), .load(load),
    .clear(clear), .operand1(operand1), .operand2(operand2),
    .op_select(op_select), .resultado(resultado), .result(result),
    .result_valid(result_valid), .div_zero(div_zero), .state(state)
  );

  always #5 clk = ~clk;

  // Calculator stand-in: add, sub, mul, div, mod; divide by zero yields 0.
  always_comb begin
    resultado = '0;
    case (op_select)
      4'd0: resultado = {4'b0, operand1} + {4'b0, operand2};
      4'd1: resultado = {4'b0, operand1} - {4'b0, operand2};
      4'd2: resultado = {4'b0, operand1} * {4'b0, operand2};
      4'd3: resultado = (operand2 == 0) ? 8'h00 : {4'b0, operand1 / operand2};
      4'd4: resultado = (operand2 == 0) ? 8'h00 : {4'b0, operand1 % operand2};
      default: resultado = '0;
    endcase
  end

  // {operand1, operand2, op_select, result, result_valid, div_zero, state}
  logic [24:0] obs;
  assign obs = {operand1, operand2, op_select, result, result_valid, div_zero, state};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Press load for one edge; returns 1ns after the capturing edge, load low.
  task automatic load_pulse(input logic [3:0] d, input logic [3:0] op);
    data_in = d; op_in = op; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Returns with the FSM in EXEC.
  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    load_pulse(a, 4'd0); tick();
    load_pulse(b, 4'd0); tick();
    load_pulse(4'd0, op);
  endtask

  task automatic do_clear;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    compared++;
    if (obs !== 25'h0) begin mismatched++; $display("FAIL reset_async: got %h want %h", obs, 25'h0); end
    tick(); rst = 1'b0; tick();
    compared++;
    if (obs !== 25'h0) begin mismatched++; $display("FAIL reset_release: got %h want %h", obs, 25'h0); end
  endtask

  task automatic test_add;
    enter(4'd3, 4'd5, 4'd0);
    compared++;
    if (obs !== {4'd3, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 3'd3})
      begin mismatched++; $display("FAIL add_exec: got %h want %h", obs, {4'd3, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 3'd3}); end
    tick();
    compared++;
    if (obs !== {4'd3, 4'd5, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4})
      begin mismatched++; $display("FAIL add_done: got %h want %h", obs, {4'd3, 4'd5, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4}); end
  endtask

  task automatic test_mul;
    do_clear();
    enter(4'd15, 4'd15, 4'd2); tick();
    compared++;
    if (obs !== {4'd15, 4'd15, 4'd2, 8'hE1, 1'b1, 1'b0, 3'd4})
      begin mismatched++; $display("FAIL mul_full: got %h want %h", obs, {4'd15, 4'd15, 4'd2, 8'hE1, 1'b1, 1'b0, 3'd4}); end
  endtask

  task automatic test_div_zero;
    do_clear();
    enter(4'd9, 4'd0, 4'd3); tick();
    compared++;
    if (obs !== {4'd9, 4'd0, 4'd3, 8'h00, 1'b1, 1'b1, 3'd4})
      begin mismatched++; $display("FAIL div_zero: got %h want %h", obs, {4'd9, 4'd0, 4'd3, 8'h00, 1'b1, 1'b1, 3'd4}); end
    do_clear();
    enter(4'd9, 4'd0, 4'd4); tick();
    compared++;
    if (obs !== {4'd9, 4'd0, 4'd4, 8'h00, 1'b1, 1'b1, 3'd4})
      begin mismatched++; $display("FAIL mod_zero: got %h want %h", obs, {4'd9, 4'd0, 4'd4, 8'h00, 1'b1, 1'b1, 3'd4}); end
    do_clear();
    enter(4'd9, 4'd3, 4'd3); tick();
    compared++;
    if (obs !== {4'd9, 4'd3, 4'd3, 8'h03, 1'b1, 1'b0, 3'd4})
      begin mismatched++; $display("FAIL div_nonzero: got %h want %h", obs, {4'd9, 4'd3, 4'd3, 8'h03, 1'b1, 1'b0, 3'd4}); end
  endtask

  task automatic test_held_load;
    do_clear();
    data_in = 4'd6; load = 1'b1;
    tick();
    data_in = 4'd9;
    repeat (9) tick();
    compared++;
    if (obs !== {4'd6, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1})
      begin mismatched++; $display("FAIL held_load: got %h want %h", obs, {4'd6, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1}); end
    load = 1'b0; tick();
  endtask

  task automatic test_exec_ignore;
    load_pulse(4'd2, 4'd0); tick();
    load_pulse(4'd0, 4'd0);
    data_in = 4'd12; load = 1'b1;   // new press lands on the EXEC edge
    tick();
    compared++;
    if (obs !== {4'd6, 4'd2, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4})
      begin mismatched++; $display("FAIL exec_ignore: got %h want %h", obs, {4'd6, 4'd2, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4}); end
    repeat (3) tick();
    load = 1'b0;
    repeat (3) tick();
    compared++;
    if (obs !== {4'd6, 4'd2, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4})
      begin mismatched++; $display("FAIL exec_not_queued: got %h want %h", obs, {4'd6, 4'd2, 4'd0, 8'h08, 1'b1, 1'b0, 3'd4}); end
  endtask

  task automatic test_done_reload;
    load_pulse(4'd7, 4'd0);
    compared++;
    if (obs !== {4'd7, 4'd2, 4'd0, 8'h08, 1'b0, 1'b0, 3'd1})
      begin mismatched++; $display("FAIL done_reload: got %h want %h", obs, {4'd7, 4'd2, 4'd0, 8'h08, 1'b0, 1'b0, 3'd1}); end
    tick();
  endtask

  task automatic test_clear;
    do_clear();
    load_pulse(4'd4, 4'd0); tick();
    load_pulse(4'd2, 4'd0); tick();
    op_in = 4'd2; load = 1'b1; clear = 1'b1;
    tick();
    compared++;
    if (obs !== 25'h0) begin mismatched++; $display("FAIL clear_vs_load: got %h want %h", obs, 25'h0); end
    clear = 1'b0; load = 1'b0; tick();
    enter(4'd3, 4'd5, 4'd0); tick();
    do_clear();
    compared++;
    if (obs !== 25'h0) begin mismatched++; $display("FAIL clear_done: got %h want %h", obs, 25'h0); end
  endtask

  task automatic test_async_reset;
    enter(4'd3, 4'd5, 4'd0);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (obs !== 25'h0) begin mismatched++; $display("FAIL reset_in_exec: got %h want %h", obs, 25'h0); end
    data_in = 4'd11; load = 1'b1;
    #2 rst = 1'b0;
    tick();
    compared++;
    if (obs !== {4'd11, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1})
      begin mismatched++; $display("FAIL load_across_reset: got %h want %h", obs, {4'd11, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1}); end
    repeat (3) tick();
    compared++;
    if (obs !== {4'd11, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1})
      begin mismatched++; $display("FAIL load_across_reset_once: got %h want %h", obs, {4'd11, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 3'd1}); end
    load = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div_zero();
    test_held_load();
    test_exec_ignore();
    test_done_reload();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits; results are 2*N bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  input  N  operand value from switches.
REQ-005 SHALL have port op_in  input  4  operation code from switches, same encoding as the calculator's op_select.
REQ-006 SHALL have port load  input  1  level from a synchronized button; each rising edge is one load event.
REQ-007 SHALL have port clear  input  1  synchronous abort, active-high.
REQ-008 SHALL have port operand1  output  N  registered first operand, driven to the calculator.
REQ-009 SHALL have port operand2  output  N  registered second operand, driven to the calculator.
REQ-010 SHALL have port op_select  output  4  registered operation code, driven to the calculator.
REQ-011 SHALL have port resultado  input  2*N  combinational result returned by the calculator.
REQ-012 SHALL have port result  output  2*N  captured result for the display.
REQ-013 SHALL have port result_valid  output  1  high while result holds a completed calculation.
REQ-014 SHALL have port div_zero  output  1  high with result_valid when op was 4'b0011 or 4'b0100 and operand2 was 0.
REQ-015 SHALL have port state  output  3  current FSM state encoding, for debug LEDs.

Function
REQ-016 SHALL form load_evt = load & ~load_q, where load_q is load registered on clk.
  - A held-high load yields exactly one event.
REQ-017 SHALL implement FSM states with encodings: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, DONE=4.
REQ-018 In GET_A, on load_evt, SHALL set operand1<=data_in and go to GET_B; otherwise SHALL hold.
REQ-019 In GET_B, on load_evt, SHALL set operand2<=data_in and go to GET_OP; otherwise SHALL hold.
REQ-020 In GET_OP, on load_evt, SHALL set op_select<=op_in and go to EXEC; otherwise SHALL hold.
REQ-021 EXEC SHALL last exactly one cycle, then:
  - result<=resultado
  - result_valid<=1
  - div_zero<=(op_select==4'b0011 or 4'b0100) && operand2==0
  - go to DONE
REQ-022 Latency: with load_evt in GET_OP at cycle k, result_valid SHALL first be high at cycle k+2.
REQ-023 In DONE, outputs SHALL stay stable until load_evt; on load_evt:
  - operand1<=data_in
  - result_valid<=0, div_zero<=0
  - result keeps its old value
  - go to GET_B
REQ-024 load_evt during EXEC SHALL be ignored and SHALL NOT be queued.
REQ-025 clear=1 SHALL, in any state, on the next edge:
  - set operand1, operand2, op_select, result, result_valid and div_zero to 0
  - go to GET_A
  - clear SHALL have priority over a simultaneous load_evt.
REQ-026 result SHALL capture all 2*N bits of resultado unmodified; narrower calculator results arrive zero-extended.
REQ-027 operand1, operand2 and op_select SHALL change only in the states named above, so the calculator inputs stay stable through EXEC and DONE.
REQ-028 Undefined state encodings (5-7) SHALL transition to GET_A on the next edge.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force:
  - state=GET_A
  - operand1, operand2, op_select, result = 0
  - result_valid = 0, div_zero = 0
  - load_q = 0
REQ-030 Reset asserted mid-sequence (any state) SHALL discard partial operands; after release the first load_evt SHALL capture operand1.
REQ-031 A load held high across reset release SHALL produce one load_evt, on the first edge after release.

Verification
REQ-032 Add path, N=4: loads 3, 5, op 4'b0000 -> result=8'h08, result_valid=1 exactly 2 cycles after the third load edge; state=4.
REQ-033 Multiply, full width: loads 15, 15, op 4'b0010 -> result=8'hE1; div_zero=0.
REQ-034 Divide by zero: loads 9, 0, op 4'b0011 -> result_valid=1, div_zero=1; repeat with op 4'b0100 -> div_zero=1.
REQ-035 Held and repeated loads:
  - load held high 10 cycles in GET_A -> only operand1 captured, state=1.
  - load edge during EXEC -> ignored.
  - load edge in DONE with data_in=7 -> operand1=7, result_valid=0, state=1.
REQ-036 Clear and reset:
  - clear together with load_evt in GET_OP -> all outputs 0, state=0, op_select unchanged from 0.
  - rst pulsed between clock edges in EXEC -> outputs 0 before the next edge.
